// File: rtl/stump_mem_responder_pkg.sv
// stump_mem_responder_pkg: state codes, error data and address check shared by the memory responder
package stump_mem_responder_pkg;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'b00,
        MEM_WAIT = 2'b01,
        MEM_ACK  = 2'b10
    } mem_state_t;

    localparam logic [15:0] MEM_ERR_DATA = 16'h0000;

    function automatic logic addr_ok(input logic [15:0] a, input int depth);
        return 32'(a) < 32'(depth);
    endfunction

endpackage

// File: rtl/stump_mem_array.sv
// stump_mem_array: DEPTH x 16 RAM, synchronous write, registered read, contents not reset
//  clk    in  clock
//  we     in  write enable; waddr/wdata written on the rising edge
//  re     in  read enable; rdata loads mem[raddr] on the rising edge, otherwise holds
module stump_mem_array #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [15:0]   rdata
);

    logic [15:0] mem [DEPTH];
    logic [15:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/stump_mem_responder.sv
// stump_mem_responder: wait-state memory responder for the Stump datapath
//  clk, rst_n          clock, asynchronous active-low reset
//  mem_ren, mem_wen    read / write request, sampled in IDLE only
//  fetch               tags the request as an instruction fetch
//  addr, wdata         word address and write data, captured with the request
//  rdata               read data, valid with mem_ready, held until the next read
//  mem_ready, err      one-cycle completion pulse; err marks an illegal access
//  busy                request accepted and not yet completed
//  fetch_cnt           count of error-free completed fetches, wraps
module stump_mem_responder
    import stump_mem_responder_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic        fetch,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        mem_ready,
    output logic        busy,
    output logic        err,
    output logic [15:0] fetch_cnt
);

    localparam int AW = $clog2(DEPTH);

    mem_state_t    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d, rd_addr;
    logic [15:0]   wdata_q, wdata_d, fetch_cnt_q, fetch_cnt_d, ram_rdata;
    logic          ren_q, ren_d, wen_q, wen_d, fetch_q, fetch_d, err_q, err_d;
    logic          busy_q, busy_d, rzero_q, rzero_d;
    logic          req, idle, cap, req_err, rd_ren, rd_err, ram_re, ram_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= MEM_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        req     = mem_ren | mem_wen;
        state_d = state_q == MEM_IDLE ? (req ? (WAIT_STATES == 0 ? MEM_ACK : MEM_WAIT) : MEM_IDLE) :
                  state_q == MEM_WAIT ? (cnt_q == 4'd1 ? MEM_ACK : MEM_WAIT) : MEM_IDLE;
    end

    always_comb begin
        mem_ready = state_q == MEM_ACK;
        err       = mem_ready && err_q;
        busy      = busy_q;
        rdata     = rzero_q ? MEM_ERR_DATA : ram_rdata;
        fetch_cnt = fetch_cnt_q;
    end

    always_comb begin
        idle      = state_q == MEM_IDLE;
        cap       = idle && req;
        req_err   = (mem_ren && mem_wen) || !addr_ok(addr, DEPTH);
        cnt_d     = cap ? 4'(WAIT_STATES) : state_q == MEM_WAIT ? cnt_q - 4'd1 : cnt_q;
        addr_d    = cap ? addr[AW-1:0] : addr_q;
        wdata_d   = cap ? wdata : wdata_q;
        ren_d     = cap ? mem_ren : ren_q;
        wen_d     = cap ? mem_wen : wen_q;
        fetch_d   = cap ? fetch : fetch_q;
        err_d     = cap ? req_err : err_q;
        // With zero wait states ACK is entered on the capture edge, so the read
        // must come straight from the inputs rather than the request registers.
        rd_ren    = idle ? mem_ren : ren_q;
        rd_err    = idle ? req_err : err_q;
        rd_addr   = idle ? addr[AW-1:0] : addr_q;
        ram_re    = state_d == MEM_ACK && rd_ren && !rd_err;
        ram_we    = state_q == MEM_ACK && wen_q && !err_q;
        // rzero masks the RAM output: set out of reset and by failed reads.
        rzero_d   = (state_d == MEM_ACK && rd_ren) ? rd_err : rzero_q;
        busy_d    = state_d == MEM_WAIT || (state_d == MEM_ACK && state_q == MEM_WAIT);
        fetch_cnt_d = fetch_cnt_q + 16'(state_q == MEM_ACK && fetch_q && !err_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ren_q       <= 1'b0;
            wen_q       <= 1'b0;
            fetch_q     <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            rzero_q     <= 1'b1;
            fetch_cnt_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ren_q       <= ren_d;
            wen_q       <= wen_d;
            fetch_q     <= fetch_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            rzero_q     <= rzero_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    stump_mem_array #(.DEPTH(DEPTH)) u_array (
        .clk   (clk),
        .we    (ram_we),
        .waddr (addr_q),
        .wdata (wdata_q),
        .re    (ram_re),
        .raddr (rd_addr),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_stump_mem_responder.sv
// tb_stump_mem_responder: randomized checks of two responders (0 and 2 wait states) against a word-array model
module tb_stump_mem_responder;

    logic        clk = 1'b0, rst_n, mem_ren = 1'b0, mem_wen = 1'b0, fetch = 1'b0;
    logic [15:0] addr = '0, wdata = '0;
    logic [15:0] rdata0, rdata2, fc0, fc2;
    logic        rdy0, rdy2, busy0, busy2, err0, err2;

    always #5 clk = ~clk;

    stump_mem_responder #(.DEPTH(256), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .mem_ren(mem_ren), .mem_wen(mem_wen), .fetch(fetch),
        .addr(addr), .wdata(wdata), .rdata(rdata0), .mem_ready(rdy0), .busy(busy0),
        .err(err0), .fetch_cnt(fc0)
    );

    stump_mem_responder #(.DEPTH(256), .WAIT_STATES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .mem_ren(mem_ren), .mem_wen(mem_wen), .fetch(fetch),
        .addr(addr), .wdata(wdata), .rdata(rdata2), .mem_ready(rdy2), .busy(busy2),
        .err(err2), .fetch_cnt(fc2)
    );

    int          n_checks = 0, n_fail = 0;
    logic [15:0] m [256];
    bit          wr [256];
    logic [15:0] exp_rd = '0, exp_fc = '0;
    int          lat0, lat2;
    logic [15:0] rd0, rd2;
    bit          e0, e2, bz0, bz2;

    // Reference: what one access must do to the word array, rdata and fetch count.
    task automatic model(input bit r, input bit w, input bit f, input logic [15:0] a,
                         input logic [15:0] d, output bit e);
        e = (r && w) || a >= 16'd256;
        if (r) exp_rd = e ? 16'h0000 : m[a[7:0]];
        if (w && !e) begin
            m[a[7:0]]  = d;
            wr[a[7:0]] = 1'b1;
        end
        if (f && !e) exp_fc++;
    endtask

    // One-cycle request pulse to both DUTs; latency counted in cycles after the capture edge.
    task automatic access(input bit r, input bit w, input bit f, input logic [15:0] a,
                          input logic [15:0] d);
        lat0 = -1; lat2 = -1; bz0 = 0; bz2 = 0; e0 = 0; e2 = 0; rd0 = 'x; rd2 = 'x;
        @(negedge clk);
        mem_ren = r; mem_wen = w; fetch = f; addr = a; wdata = d;
        @(posedge clk);
        for (int c = 1; c <= 12 && (lat0 < 0 || lat2 < 0); c++) begin
            @(negedge clk);
            mem_ren = 0; mem_wen = 0; fetch = 0;
            addr = 16'($urandom); wdata = 16'($urandom);
            bz0 |= busy0; bz2 |= busy2;
            if (rdy0 && lat0 < 0) begin lat0 = c; rd0 = rdata0; e0 = err0; end
            if (rdy2 && lat2 < 0) begin lat2 = c; rd2 = rdata2; e2 = err2; end
        end
        @(negedge clk);
        bz0 |= busy0; bz2 |= busy2;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++; if ({rdy0, busy0, err0} !== 3'b000) begin n_fail++; $display("FAIL reset_flags0 got %b want 000", {rdy0, busy0, err0}); end
        n_checks++; if ({rdy2, busy2, err2} !== 3'b000) begin n_fail++; $display("FAIL reset_flags2 got %b want 000", {rdy2, busy2, err2}); end
        n_checks++; if (rdata0 !== 16'h0 || rdata2 !== 16'h0) begin n_fail++; $display("FAIL reset_rdata got %h/%h want 0000", rdata0, rdata2); end
        n_checks++; if (fc0 !== 16'h0 || fc2 !== 16'h0) begin n_fail++; $display("FAIL reset_fcnt got %h/%h want 0000", fc0, fc2); end
        rst_n = 1'b1;
        exp_rd = '0; exp_fc = '0;
    endtask

    task automatic test_ws2();
        bit e;
        model(0, 1, 0, 16'h0010, 16'hBEEF, e);
        access(0, 1, 0, 16'h0010, 16'hBEEF);
        n_checks++; if (lat2 !== 3) begin n_fail++; $display("FAIL ws2_write_lat got %0d want 3", lat2); end
        n_checks++; if (e2 !== 1'b0) begin n_fail++; $display("FAIL ws2_write_err got %b want 0", e2); end
        model(1, 0, 0, 16'h0010, 16'h0, e);
        access(1, 0, 0, 16'h0010, 16'h0);
        n_checks++; if (lat2 !== 3) begin n_fail++; $display("FAIL ws2_read_lat got %0d want 3", lat2); end
        n_checks++; if (rd2 !== 16'hBEEF) begin n_fail++; $display("FAIL ws2_read_data got %h want beef", rd2); end
        n_checks++; if (bz2 !== 1'b1) begin n_fail++; $display("FAIL ws2_busy got %b want 1", bz2); end
    endtask

    task automatic test_ws0();
        bit e;
        model(1, 0, 1, 16'h0010, 16'h0, e);
        access(1, 0, 1, 16'h0010, 16'h0);
        n_checks++; if (lat0 !== 1) begin n_fail++; $display("FAIL ws0_lat got %0d want 1", lat0); end
        n_checks++; if (rd0 !== 16'hBEEF) begin n_fail++; $display("FAIL ws0_data got %h want beef", rd0); end
        n_checks++; if (bz0 !== 1'b0) begin n_fail++; $display("FAIL ws0_busy got %b want 0", bz0); end
        n_checks++; if (fc0 !== exp_fc) begin n_fail++; $display("FAIL ws0_fcnt got %h want %h", fc0, exp_fc); end
    endtask

    task automatic test_illegal();
        bit e;
        model(0, 1, 0, 16'h0004, 16'h1234, e);
        access(0, 1, 0, 16'h0004, 16'h1234);
        model(1, 1, 1, 16'h0004, 16'h5555, e);
        access(1, 1, 1, 16'h0004, 16'h5555);
        n_checks++; if ({e0, e2} !== 2'b11) begin n_fail++; $display("FAIL both_err got %b want 11", {e0, e2}); end
        n_checks++; if (rd0 !== 16'h0 || rd2 !== 16'h0) begin n_fail++; $display("FAIL both_rdata got %h/%h want 0000", rd0, rd2); end
        n_checks++; if (fc0 !== exp_fc) begin n_fail++; $display("FAIL both_fcnt got %h want %h", fc0, exp_fc); end
        model(1, 0, 0, 16'h0004, 16'h0, e);
        access(1, 0, 0, 16'h0004, 16'h0);
        n_checks++; if (rd0 !== 16'h1234 || rd2 !== 16'h1234) begin n_fail++; $display("FAIL both_word got %h/%h want 1234", rd0, rd2); end
        n_checks++; if ({e0, e2} !== 2'b00) begin n_fail++; $display("FAIL both_reread_err got %b want 00", {e0, e2}); end
    endtask

    task automatic test_oob();
        bit e;
        model(0, 1, 0, 16'h0000, 16'hA5A5, e);
        access(0, 1, 0, 16'h0000, 16'hA5A5);
        model(0, 1, 0, 16'h0100, 16'h7777, e);
        access(0, 1, 0, 16'h0100, 16'h7777);
        n_checks++; if ({e0, e2} !== 2'b11) begin n_fail++; $display("FAIL oob_write_err got %b want 11", {e0, e2}); end
        model(1, 0, 1, 16'h0100, 16'h0, e);
        access(1, 0, 1, 16'h0100, 16'h0);
        n_checks++; if ({e0, e2} !== 2'b11) begin n_fail++; $display("FAIL oob_read_err got %b want 11", {e0, e2}); end
        n_checks++; if (rd0 !== 16'h0 || rd2 !== 16'h0) begin n_fail++; $display("FAIL oob_read_data got %h/%h want 0000", rd0, rd2); end
        n_checks++; if (fc0 !== exp_fc) begin n_fail++; $display("FAIL oob_fcnt got %h want %h", fc0, exp_fc); end
        model(1, 0, 0, 16'h0000, 16'h0, e);
        access(1, 0, 0, 16'h0000, 16'h0);
        n_checks++; if (rd0 !== 16'hA5A5 || rd2 !== 16'hA5A5) begin n_fail++; $display("FAIL oob_alias got %h/%h want a5a5", rd0, rd2); end
    endtask

    task automatic test_random();
        bit r, w, f, e;
        int s;
        logic [15:0] a, d;
        for (int i = 0; i < 60; i++) begin
            s = $urandom_range(0, 9);
            r = s < 5 || s == 9;
            w = s >= 5;
            f = $urandom_range(0, 1) == 1;
            a = $urandom_range(0, 4) == 0 ? 16'h0100 + 16'($urandom_range(0, 16'hFEFF)) : 16'($urandom_range(0, 255));
            d = 16'($urandom);
            if (r && !w && a < 16'd256 && !wr[a[7:0]]) begin r = 0; w = 1; end
            model(r, w, f, a, d, e);
            access(r, w, f, a, d);
            n_checks++; if (lat0 !== 1 || lat2 !== 3) begin n_fail++; $display("FAIL rnd_lat[%0d] got %0d/%0d want 1/3", i, lat0, lat2); end
            n_checks++; if (e0 !== e || e2 !== e) begin n_fail++; $display("FAIL rnd_err[%0d] got %b/%b want %b", i, e0, e2, e); end
            n_checks++; if (rd0 !== exp_rd || rd2 !== exp_rd) begin n_fail++; $display("FAIL rnd_rdata[%0d] a=%h got %h/%h want %h", i, a, rd0, rd2, exp_rd); end
            n_checks++; if (fc0 !== exp_fc || fc2 !== exp_fc) begin n_fail++; $display("FAIL rnd_fcnt[%0d] got %h/%h want %h", i, fc0, fc2, exp_fc); end
        end
    endtask

    task automatic test_mid_reset();
        bit e;
        int pulses = 0;
        @(negedge clk);
        mem_wen = 1; fetch = 1; addr = 16'h0010; wdata = 16'h1111;
        @(negedge clk);
        mem_wen = 0; fetch = 0;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({rdy0, busy0, err0, rdy2, busy2, err2} !== 6'b0) begin n_fail++; $display("FAIL midrst_flags got %b want 000000", {rdy0, busy0, err0, rdy2, busy2, err2}); end
        n_checks++; if (fc0 !== 16'h0 || fc2 !== 16'h0) begin n_fail++; $display("FAIL midrst_fcnt got %h/%h want 0000", fc0, fc2); end
        n_checks++; if (rdata0 !== 16'h0 || rdata2 !== 16'h0) begin n_fail++; $display("FAIL midrst_rdata got %h/%h want 0000", rdata0, rdata2); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_rd = '0; exp_fc = '0;
        repeat (5) begin
            @(negedge clk);
            pulses += int'(rdy0) + int'(rdy2);
        end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL midrst_ready got %0d pulses want 0", pulses); end
        model(1, 0, 0, 16'h0010, 16'h0, e);
        access(1, 0, 0, 16'h0010, 16'h0);
        n_checks++; if (rd0 !== exp_rd || rd2 !== exp_rd) begin n_fail++; $display("FAIL midrst_word got %h/%h want %h", rd0, rd2, exp_rd); end
    endtask

    task automatic test_fetch_wrap();
        bit e;
        logic [15:0] a;
        a = 16'h0004;
        for (int i = 0; i < 6; i++) begin
            model(1, 0, 1, a, 16'h0, e);
            access(1, 0, 1, a, 16'h0);
        end
        n_checks++; if (fc0 !== exp_fc) begin n_fail++; $display("FAIL fcnt_count got %h want %h", fc0, exp_fc); end
        @(negedge clk);
        force dut0.fetch_cnt_q = 16'hFFFD;
        @(posedge clk);
        #1 release dut0.fetch_cnt_q;
        exp_fc = 16'hFFFD;
        for (int i = 0; i < 5; i++) begin
            model(1, 0, i != 2, a, 16'h0, e);
            access(1, 0, i != 2, a, 16'h0);
            n_checks++; if (fc0 !== exp_fc) begin n_fail++; $display("FAIL fcnt_wrap[%0d] got %h want %h", i, fc0, exp_fc); end
        end
    endtask

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        test_reset();
        test_ws2();
        test_ws0();
        test_illegal();
        test_oob();
        test_random();
        test_mid_reset();
        test_fetch_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
